seq_mag_comparator: RTL

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

---
 rtl/seq_mag_comparator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator
//   Sequential magnitude comparator. The operands are compared SLICE bits per
//   clock, starting with the most-significant slice. The compare stops at the
//   first slice that differs. When every slice is equal, the captured cascade
//   inputs decide the result, so several stages can be chained.
//
// Parameters
//   WIDTH  operand width (integer multiple of SLICE, >= SLICE)
//   SLICE  bits compared per clock
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   start                   request; sampled only in IDLE
//   a, b                    operands, captured on accepted start
//   signed_mode             1 = two's-complement, 0 = unsigned (captured)
//   eq_in, gt_in, lt_in     cascade from a less-significant stage (captured)
//   busy                    high in CMP and DONE
//   done                    one-cycle pulse with a valid result
//   eq, gt, lt              registered one-hot result, held until next start
// ---------------------------------------------------------------------------
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                       state;
  logic [IDXW-1:0]              idx;
  // Operands are held as slice arrays so the active slice is a plain index.
  logic [NSLICE-1:0][SLICE-1:0] a_q, b_q;
  logic                         sm_q;
  logic [2:0]                   casc_q;   // {gt_in, lt_in, eq_in}

  logic [SLICE-1:0] sa, sb;
  logic             slice_gt;

  // Active slice. In signed mode the sign bit is inverted on the top slice
  // only, which maps two's-complement order onto unsigned order. The lower
  // slices are magnitude bits and compare unsigned.
  always_comb begin
    sa = a_q[idx];
    sb = b_q[idx];
    if (sm_q && (idx == TOP_IDX)) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
    slice_gt = (sa > sb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= 1'b0;
      casc_q <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sm_q   <= signed_mode;
            casc_q <= {gt_in, lt_in, eq_in};
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            idx    <= TOP_IDX;
            busy   <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          if (sa != sb) begin
            // The first differing slice decides; lower slices are skipped.
            gt    <= slice_gt;
            lt    <= ~slice_gt;
            eq    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (idx != '0) begin
            idx <= idx - IDXW'(1);
          end else begin
            // All slices equal: the cascade decides, gt_in > lt_in > eq_in.
            // All-zero cascade is treated as equal.
            casez (casc_q)
              3'b1??:  begin gt <= 1'b1; lt <= 1'b0; eq <= 1'b0; end
              3'b01?:  begin gt <= 1'b0; lt <= 1'b1; eq <= 1'b0; end
              3'b001:  begin gt <= 1'b0; lt <= 1'b0; eq <= 1'b1; end
              default: begin gt <= 1'b0; lt <= 1'b0; eq <= 1'b1; end
            endcase
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // A start seen here is dropped; the next IDLE cycle samples again.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
